gpio_seq_receiver: RTL and testbench



---
 rtl/gpio_seq_receiver.sv | 125 ++++++++++++
 tb/tb_gpio_seq_receiver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_seq_receiver.sv
// Device-side responder for the GPIO element-transfer handshake: collects ELEMS
// 15-bit elements from gpio_switch and presents them as a matrix until released.
module gpio_seq_receiver #(
    parameter int ELEMS    = 16,
    parameter int ACK_HOLD = 2,
    parameter bit SYNC_IN  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] gpio_switch,
    output logic [15:0] gpio_led,
    output logic [15:0] matrix_o [ELEMS],
    output logic        matrix_valid,
    input  logic        matrix_ack,
    output logic        proto_err
);

    localparam int IDX_W  = $clog2(ELEMS + 1);
    localparam int HOLD_W = $clog2(ACK_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE,
        FULL
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                ack_q;
    logic [15:0]         sw;

    generate
        if (SYNC_IN) begin : g_sync
            logic [15:0] sync_q1;
            logic [15:0] sync_q2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q1 <= '0;
                    sync_q2 <= '0;
                end else begin
                    sync_q1 <= gpio_switch;
                    sync_q2 <= sync_q1;
                end
            end

            assign sw = sync_q2;
        end else begin : g_nosync
            assign sw = gpio_switch;
        end
    endgenerate

    assign gpio_led = {ack_q, {(15 - IDX_W){1'b0}}, idx};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            hold_cnt     <= '0;
            ack_q        <= 1'b0;
            matrix_valid <= 1'b0;
            proto_err    <= 1'b0;
            // NOTE: the matrix storage is reset as well, so a consumer never sees stale elements after reset.
            for (int i = 0; i < ELEMS; i++) begin
                matrix_o[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (sw[15]) begin
                        for (int i = 0; i < ELEMS; i++) begin
                            if (idx == IDX_W'(i)) begin
                                matrix_o[i] <= {1'b0, sw[14:0]};
                            end
                        end
                        ack_q    <= 1'b1;
                        hold_cnt <= HOLD_W'(ACK_HOLD);
                        state    <= ACK;
                    end
                end

                ACK: begin
                    // The expiry edge wins over a dropped valid: the hold time has been served.
                    if (hold_cnt == HOLD_W'(1)) begin
                        ack_q    <= 1'b0;
                        hold_cnt <= '0;
                        state    <= RELEASE;
                    end else if (!sw[15]) begin
                        proto_err <= 1'b1;
                        ack_q     <= 1'b0;
                        hold_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end

                RELEASE: begin
                    if (!sw[15]) begin
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(ELEMS - 1)) begin
                            matrix_valid <= 1'b1;
                            state        <= FULL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                FULL: begin
                    if (matrix_ack) begin
                        matrix_valid <= 1'b0;
                        idx          <= '0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_seq_receiver.sv
// Self-checking bench for gpio_seq_receiver: scoreboarded matrix transfers on a
// 16-element instance plus ack-width and abort checks on small auxiliary instances.
module tb_gpio_seq_receiver;

    localparam int N  = 16;
    localparam int AN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] sw;
    logic [15:0] led;
    logic [15:0] mat [N];
    logic        valid;
    logic        ack;
    logic        err;

    logic [15:0] aux_sw;
    logic        aux_ack;
    logic [15:0] led1, led3, led4;
    logic [15:0] m1 [AN];
    logic [15:0] m3 [AN];
    logic [15:0] m4 [AN];
    logic        v1, v3, v4;
    logic        e1, e3, e4;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_mat    = 0;
    logic [15:0] exp_q [$];
    bit          valid_d  = 1'b0;

    gpio_seq_receiver #(.ELEMS(N), .ACK_HOLD(2)) dut (
        .clk(clk), .rst_n(rst_n), .gpio_switch(sw), .gpio_led(led),
        .matrix_o(mat), .matrix_valid(valid), .matrix_ack(ack), .proto_err(err)
    );

    gpio_seq_receiver #(.ELEMS(AN), .ACK_HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .gpio_switch(aux_sw), .gpio_led(led1),
        .matrix_o(m1), .matrix_valid(v1), .matrix_ack(aux_ack), .proto_err(e1)
    );

    gpio_seq_receiver #(.ELEMS(AN), .ACK_HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .gpio_switch(aux_sw), .gpio_led(led3),
        .matrix_o(m3), .matrix_valid(v3), .matrix_ack(aux_ack), .proto_err(e3)
    );

    gpio_seq_receiver #(.ELEMS(AN), .ACK_HOLD(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .gpio_switch(aux_sw), .gpio_led(led4),
        .matrix_o(m4), .matrix_valid(v4), .matrix_ack(aux_ack), .proto_err(e4)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ack_bit(input int sel);
        return (sel == 0) ? led[15] : led4[15];
    endfunction

    // Bounded wait for the acknowledge of the main (sel=0) or ACK_HOLD=4 instance.
    task automatic wait_ack(input int sel, input logic val, input string tag);
        int n = 0;
        while (ack_bit(sel) !== val && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(ack_bit(sel)), 32'(val));
    endtask

    task automatic send(input logic [15:0] w);
        sw = w | 16'h8000;
        exp_q.push_back({1'b0, w[14:0]});
        wait_ack(0, 1'b1, "ack_rise");
        wait_ack(0, 1'b0, "ack_fall");
        sw = 16'h0000;
        tick();
    endtask

    // Scoreboard monitor: a rising matrix_valid pops one expected matrix.
    always @(posedge clk) begin
        #2;
        if (valid === 1'b1 && !valid_d) begin
            for (int i = 0; i < N; i++) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(1), 32'(0));
                end else begin
                    check($sformatf("mat%0d", i), 32'(mat[i]), 32'(exp_q.pop_front()));
                end
            end
            n_mat++;
        end
        valid_d = (valid === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt1, cnt3, cnt4, f1, f3;

        rst_n   = 1'b0;
        sw      = 16'h0000;
        ack     = 1'b0;
        aux_sw  = 16'h0000;
        aux_ack = 1'b0;
        tick();
        tick();
        check("rst_led", 32'(led), 32'(0));
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        check("rst_mat0", 32'(mat[0]), 32'(0));
        check("rst_mat15", 32'(mat[15]), 32'(0));
        rst_n = 1'b1;
        tick();

        // Full transfer of 0x0001..0x0010.
        for (int i = 0; i < N; i++) begin
            send(16'(i + 1));
        end
        check("full_valid", 32'(valid), 32'(1));
        check("full_count", 32'(led[14:0]), 32'(N));
        check("full_err", 32'(err), 32'(0));
        tick();
        check("full_nmat", 32'(n_mat), 32'(1));

        // Backpressure: a valid word in FULL gets no acknowledge.
        sw = 16'h8123;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("bp_ack%0d", c), 32'(led[15]), 32'(0));
        end
        check("bp_valid", 32'(valid), 32'(1));
        check("bp_frozen", 32'(mat[0]), 32'(16'h0001));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("rel_valid", 32'(valid), 32'(0));
        check("rel_count", 32'(led[14:0]), 32'(0));
        check("rel_ack", 32'(led[15]), 32'(0));
        tick();
        check("bp_mat0", 32'(mat[0]), 32'(16'h0123));
        check("bp_ack_rise", 32'(led[15]), 32'(1));
        exp_q.push_back(16'h0123);
        wait_ack(0, 1'b0, "ack_fall");
        sw = 16'h0000;
        tick();
        check("bp_count", 32'(led[14:0]), 32'(1));

        // Reset during ACK after five commits.
        for (int i = 0; i < 4; i++) begin
            send(16'(16'h0200 + i));
        end
        check("pre_rst_count", 32'(led[14:0]), 32'(5));
        sw = 16'h8555;
        wait_ack(0, 1'b1, "rst_ack_rise");
        rst_n = 1'b0;
        tick();
        check("mid_rst_led", 32'(led), 32'(0));
        check("mid_rst_valid", 32'(valid), 32'(0));
        check("mid_rst_err", 32'(err), 32'(0));
        check("mid_rst_mat0", 32'(mat[0]), 32'(0));
        check("mid_rst_mat5", 32'(mat[5]), 32'(0));
        rst_n = 1'b1;
        sw    = 16'h0000;
        exp_q.delete();
        tick();

        // Bit-15 stripping, then fill the rest of the matrix.
        send(16'hFFFF);
        send(16'h8000);
        check("strip_mat0", 32'(mat[0]), 32'(16'h7FFF));
        check("strip_mat1", 32'(mat[1]), 32'(16'h0000));
        for (int i = 2; i < N; i++) begin
            send(16'(i * 37 + 16'h2A00));
        end
        check("strip_valid", 32'(valid), 32'(1));
        check("strip_count", 32'(led[14:0]), 32'(N));
        tick();
        check("strip_nmat", 32'(n_mat), 32'(2));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("strip_rel_valid", 32'(valid), 32'(0));

        // Acknowledge width on ACK_HOLD = 1, 3, 4.
        cnt1 = 0; cnt3 = 0; cnt4 = 0; f1 = -1; f3 = -1;
        aux_sw = 16'h8005;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (led1[15]) begin cnt1++; if (f1 < 0) f1 = c; end
            if (led3[15]) begin cnt3++; if (f3 < 0) f3 = c; end
            if (led4[15]) cnt4++;
        end
        check("width_h1", 32'(cnt1), 32'(1));
        check("width_h3", 32'(cnt3), 32'(3));
        check("width_h4", 32'(cnt4), 32'(4));
        check("rise_h1", 32'(f1), 32'(0));
        check("rise_h3", 32'(f3), 32'(0));
        aux_sw = 16'h0000;
        tick();
        check("h1_count", 32'(led1[14:0]), 32'(1));
        check("h3_count", 32'(led3[14:0]), 32'(1));
        check("h4_count", 32'(led4[14:0]), 32'(1));
        check("h1_mat0", 32'(m1[0]), 32'(16'h0005));
        check("h3_err", 32'(e3), 32'(0));
        check("h4_err0", 32'(e4), 32'(0));

        // Abort on ACK_HOLD=4: valid held for two sampled cycles only.
        aux_sw = 16'h8009;
        tick();
        tick();
        aux_sw = 16'h0000;
        tick();
        check("abort_err", 32'(e4), 32'(1));
        check("abort_ack", 32'(led4[15]), 32'(0));
        check("abort_count", 32'(led4[14:0]), 32'(1));
        tick();
        aux_sw = 16'h800A;
        wait_ack(4, 1'b1, "h4_ack_rise");
        wait_ack(4, 1'b0, "h4_ack_fall");
        aux_sw = 16'h0000;
        tick();
        check("after_abort_count", 32'(led4[14:0]), 32'(2));
        check("after_abort_mat1", 32'(m4[1]), 32'(16'h000A));
        check("after_abort_err", 32'(e4), 32'(1));

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
